// File: rtl/fifo245_responder.sv
// Device-side responder for a 245-style parallel FIFO port: a CPU-written TX FIFO drained by
// the host and a host-filled RX FIFO read by the CPU, with synchronised CPU strobes.
module fifo245_responder #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       _MR,
    input  logic       WR,
    input  logic       _RD,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       _TXE,
    output logic       _RXF,
    input  logic       host_rx_valid,
    input  logic [7:0] host_rx_data,
    output logic       host_rx_ready,
    output logic       host_tx_valid,
    output logic [7:0] host_tx_data,
    input  logic       host_tx_ready,
    output logic       tx_overflow,
    output logic       rx_underflow
);
    typedef logic [AW:0] cnt_t;
    localparam cnt_t FULL = cnt_t'(DEPTH);

    logic          wr_s1_q, wr_s1_d, wr_s2_q, wr_s2_d;
    logic          rd_s1_q, rd_s1_d, rd_s2_q, rd_s2_d;
    logic [7:0]    d_hold_q, d_hold_d;
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    cnt_t          tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
    logic          txe_q, txe_d, rxf_q, rxf_d;
    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];

    logic wr_fall, rd_rise;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;

    assign wr_fall  = wr_s2_q & ~wr_s1_q;
    assign rd_rise  = ~rd_s2_q & rd_s1_q;
    assign tx_full  = (tx_cnt_q == FULL);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL);
    assign rx_empty = (rx_cnt_q == '0);

    assign tx_push = wr_fall & ~tx_full;
    assign tx_pop  = host_tx_valid & host_tx_ready;
    assign rx_pop  = rd_rise & ~rx_empty;
    // A CPU pop in this cycle frees the head slot, so a full RX FIFO can still take a byte.
    assign host_rx_ready = ~rx_full | rx_pop;
    assign rx_push       = host_rx_valid & host_rx_ready;

    assign host_tx_valid = ~tx_empty;
    assign host_tx_data  = tx_mem[tx_rp_q];
    assign d_out         = rx_empty ? 8'hFF : rx_mem[rx_rp_q];
    assign d_oe          = ~_RD;
    assign _TXE          = txe_q;
    assign _RXF          = rxf_q;
    assign tx_overflow   = tx_ovf_q;
    assign rx_underflow  = rx_unf_q;

    always_comb begin
        wr_s1_d  = WR;
        wr_s2_d  = wr_s1_q;
        rd_s1_d  = _RD;
        rd_s2_d  = rd_s1_q;
        d_hold_d = wr_s1_q ? d_in : d_hold_q;

        tx_wp_d  = tx_push ? tx_wp_q + 1'b1 : tx_wp_q;
        tx_rp_d  = tx_pop  ? tx_rp_q + 1'b1 : tx_rp_q;
        rx_wp_d  = rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
        rx_rp_d  = rx_pop  ? rx_rp_q + 1'b1 : rx_rp_q;
        tx_cnt_d = tx_cnt_q + cnt_t'(tx_push) - cnt_t'(tx_pop);
        rx_cnt_d = rx_cnt_q + cnt_t'(rx_push) - cnt_t'(rx_pop);

        tx_ovf_d = tx_ovf_q | (wr_fall & tx_full);
        rx_unf_d = rx_unf_q | (rd_rise & rx_empty);
        // Every processed write strobe yields a one-cycle busy pulse on _TXE.
        txe_d    = (tx_cnt_d == FULL) | wr_fall;
        rxf_d    = (rx_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge _MR) begin
        if (!_MR) begin
            wr_s1_q  <= 1'b0;
            wr_s2_q  <= 1'b0;
            rd_s1_q  <= 1'b1;
            rd_s2_q  <= 1'b1;
            d_hold_q <= 8'h00;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
            txe_q    <= 1'b1;
            rxf_q    <= 1'b1;
        end else begin
            wr_s1_q  <= wr_s1_d;
            wr_s2_q  <= wr_s2_d;
            rd_s1_q  <= rd_s1_d;
            rd_s2_q  <= rd_s2_d;
            d_hold_q <= d_hold_d;
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
            txe_q    <= txe_d;
            rxf_q    <= rxf_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the counts alone.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= d_hold_q;
        if (rx_push) rx_mem[rx_wp_q] <= host_rx_data;
    end

endmodule

// File: tb/tb_fifo245_responder.sv
// Self-checking bench for fifo245_responder: directed vector table plus hand-written
// sequences for reset, full/overflow, RX wrap with same-cycle push/pop, and underflow.
module tb_fifo245_responder;
    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       _MR, WR, _RD;
    logic [7:0] d_in, d_out;
    logic       d_oe, _TXE, _RXF;
    logic       host_rx_valid, host_rx_ready, host_tx_valid, host_tx_ready;
    logic [7:0] host_rx_data, host_tx_data;
    logic       tx_overflow, rx_underflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fifo245_responder #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        ._MR           (_MR),
        .WR            (WR),
        ._RD           (_RD),
        .d_in          (d_in),
        .d_out         (d_out),
        .d_oe          (d_oe),
        ._TXE          (_TXE),
        ._RXF          (_RXF),
        .host_rx_valid (host_rx_valid),
        .host_rx_data  (host_rx_data),
        .host_rx_ready (host_rx_ready),
        .host_tx_valid (host_tx_valid),
        .host_tx_data  (host_tx_data),
        .host_tx_ready (host_tx_ready),
        .tx_overflow   (tx_overflow),
        .rx_underflow  (rx_underflow)
    );

    typedef enum logic [1:0] {OpWr, OpPush, OpDrain, OpRd} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] data;     // byte driven (Wr/Push) or byte expected (Drain/Rd)
        logic       exp_txv;
        logic       exp_rxf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [7:0] b);
        d_in = b;
        WR   = 1'b1;
        tick(3);
        WR = 1'b0;
        tick(3);
    endtask

    task automatic cpu_read(output logic [7:0] b);
        _RD = 1'b0;
        tick(1);
        b = d_out;
        tick(2);
        _RD = 1'b1;
        tick(3);
    endtask

    task automatic host_push(input logic [7:0] b);
        host_rx_valid = 1'b1;
        host_rx_data  = b;
        tick(1);
        host_rx_valid = 1'b0;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         ones;

        vecs[0] = '{OpWr,    8'h11, 1'b1, 1'b1};
        vecs[1] = '{OpWr,    8'h22, 1'b1, 1'b1};
        vecs[2] = '{OpPush,  8'h33, 1'b1, 1'b0};
        vecs[3] = '{OpDrain, 8'h11, 1'b1, 1'b0};
        vecs[4] = '{OpRd,    8'h33, 1'b1, 1'b1};
        vecs[5] = '{OpPush,  8'h44, 1'b1, 1'b0};
        vecs[6] = '{OpPush,  8'h55, 1'b1, 1'b0};
        vecs[7] = '{OpDrain, 8'h22, 1'b0, 1'b0};
        vecs[8] = '{OpRd,    8'h44, 1'b0, 1'b0};
        vecs[9] = '{OpRd,    8'h55, 1'b0, 1'b1};

        _MR = 1'b0; WR = 1'b0; _RD = 1'b1; d_in = 8'h00;
        host_rx_valid = 1'b0; host_rx_data = 8'h00; host_tx_ready = 1'b0;

        // Reset values and release
        tick(3);
        check("rst_txe", _TXE, 1'b1);
        check("rst_rxf", _RXF, 1'b1);
        check("rst_txv", host_tx_valid, 1'b0);
        check("rst_rxrdy", host_rx_ready, 1'b1);
        check("rst_ovf", tx_overflow, 1'b0);
        check("rst_unf", rx_underflow, 1'b0);
        check("rst_doe", d_oe, 1'b0);
        check("rst_dout", d_out, 8'hFF);
        _MR = 1'b1;
        tick(1);
        check("rel_txe", _TXE, 1'b0);
        check("rel_rxf", _RXF, 1'b1);

        // CPU write to host, with write-latency and busy-pulse checks on the first byte
        d_in = 8'hA5;
        WR   = 1'b1;
        tick(3);
        WR   = 1'b0;
        ones = 0;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            if (_TXE) ones++;
            if (k == 1) check("wr_txv_early", host_tx_valid, 1'b0);
            if (k == 3) begin
                check("wr_txv", host_tx_valid, 1'b1);
                check("wr_data", host_tx_data, 8'hA5);
            end
        end
        check("wr_txe_busy_cycles", 8'(ones), 8'd1);
        cpu_write(8'h3C);
        check("wr2_head", host_tx_data, 8'hA5);
        host_tx_ready = 1'b1;
        tick(1);
        check("drain1_txv", host_tx_valid, 1'b1);
        check("drain1_head", host_tx_data, 8'h3C);
        tick(1);
        check("drain2_txv", host_tx_valid, 1'b0);
        host_tx_ready = 1'b0;

        // Host to CPU read
        host_rx_valid = 1'b1;
        host_rx_data  = 8'h42;
        check("push_ready", host_rx_ready, 1'b1);
        tick(1);
        host_rx_valid = 1'b0;
        tick(1);
        check("push_rxf", _RXF, 1'b0);
        _RD = 1'b0;
        #1;
        check("rd_doe", d_oe, 1'b1);
        check("rd_dout", d_out, 8'h42);
        tick(2);
        _RD = 1'b1;
        #1;
        check("rd_doe_off", d_oe, 1'b0);
        tick(1);
        check("rd_rxf_edge1", _RXF, 1'b0);
        tick(1);
        check("rd_rxf_edge2", _RXF, 1'b1);
        check("rd_dout_empty", d_out, 8'hFF);
        check("rd_unf", rx_underflow, 1'b0);
        tick(1);

        // Mixed traffic table
        for (int i = 0; i < 10; i++) begin
            case (vecs[i].op)
                OpWr:   cpu_write(vecs[i].data);
                OpPush: host_push(vecs[i].data);
                OpDrain: begin
                    check($sformatf("vec%0d_drain", i), host_tx_data, vecs[i].data);
                    host_tx_ready = 1'b1;
                    tick(1);
                    host_tx_ready = 1'b0;
                end
                default: begin
                    cpu_read(b);
                    check($sformatf("vec%0d_rd", i), b, vecs[i].data);
                end
            endcase
            check($sformatf("vec%0d_txv", i), host_tx_valid, vecs[i].exp_txv);
            check($sformatf("vec%0d_rxf", i), _RXF, vecs[i].exp_rxf);
        end
        check("vec_unf", rx_underflow, 1'b0);

        // TX full and overflow
        for (int i = 0; i < DEPTH; i++) cpu_write(8'(i));
        check("full_txe", _TXE, 1'b1);
        check("full_ovf_pre", tx_overflow, 1'b0);
        cpu_write(8'h10);
        check("full_ovf", tx_overflow, 1'b1);
        check("full_txe_after_ovf", _TXE, 1'b1);
        host_tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain%0d_txv", i), host_tx_valid, 1'b1);
            check($sformatf("drain%0d_data", i), host_tx_data, 8'(i));
            tick(1);
            if (i == 0) check("drain_txe_free", _TXE, 1'b0);
        end
        host_tx_ready = 1'b0;
        check("drain_done_txv", host_tx_valid, 1'b0);

        // RX wrap with same-cycle push/pop at full
        host_rx_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            host_rx_data = 8'h80 + 8'(i);
            tick(1);
        end
        host_rx_data = 8'h90;
        check("rxfull_ready", host_rx_ready, 1'b0);
        check("rxfull_rxf", _RXF, 1'b0);
        _RD = 1'b0;
        tick(1);
        check("rxfull_head", d_out, 8'h80);
        tick(2);
        _RD = 1'b1;
        tick(1);
        check("rxfull_ready_on_pop", host_rx_ready, 1'b1);
        tick(1);
        host_rx_valid = 1'b0;
        check("rxfull_still_full", host_rx_ready, 1'b0);
        check("rxfull_next_head", d_out, 8'h81);
        tick(1);
        fork
            begin
                logic hs;
                int   guard;
                guard = 0;
                for (int k = 0; k < 3; k++) begin
                    host_rx_valid = 1'b1;
                    host_rx_data  = 8'h91 + 8'(k);
                    do begin
                        @(negedge clk);
                        hs = host_rx_ready;
                        @(posedge clk);
                        #1;
                        guard++;
                    end while (!hs && guard < 1000);
                end
                host_rx_valid = 1'b0;
                check("wrap_push_timeout", 8'(guard >= 1000), 8'd0);
            end
            begin
                logic [7:0] rb;
                for (int i = 0; i < 19; i++) begin
                    cpu_read(rb);
                    check($sformatf("wrap_rd%0d", i), rb, 8'h81 + 8'(i));
                end
            end
        join
        check("wrap_rxf", _RXF, 1'b1);
        check("wrap_unf", rx_underflow, 1'b0);

        // Underflow, then reset with traffic queued and strobes in flight
        _RD = 1'b0;
        tick(1);
        check("unf_doe", d_oe, 1'b1);
        check("unf_dout", d_out, 8'hFF);
        tick(2);
        _RD = 1'b1;
        tick(3);
        check("unf_flag", rx_underflow, 1'b1);
        for (int i = 0; i < 5; i++) cpu_write(8'h61 + 8'(i));
        for (int i = 0; i < 5; i++) host_push(8'h71 + 8'(i));
        check("q_txv", host_tx_valid, 1'b1);
        check("q_rxf", _RXF, 1'b0);
        check("q_ovf", tx_overflow, 1'b1);
        WR  = 1'b1;
        _RD = 1'b0;
        tick(2);
        _MR = 1'b0;
        #1;
        check("mr_txv", host_tx_valid, 1'b0);
        check("mr_rxrdy", host_rx_ready, 1'b1);
        check("mr_txe", _TXE, 1'b1);
        check("mr_rxf", _RXF, 1'b1);
        check("mr_ovf", tx_overflow, 1'b0);
        check("mr_unf", rx_underflow, 1'b0);
        check("mr_dout", d_out, 8'hFF);
        WR  = 1'b0;
        _RD = 1'b1;
        tick(3);
        _MR = 1'b1;
        tick(8);
        check("post_txv", host_tx_valid, 1'b0);
        check("post_rxf", _RXF, 1'b1);
        check("post_txe", _TXE, 1'b0);
        check("post_ovf", tx_overflow, 1'b0);
        check("post_unf", rx_underflow, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
